// File: rtl/psum_collector_pkg.sv
// psum_collector_pkg: shared types and constants for the PE-column collector path.
//   DATA_SIZE     - activation / output width (signed)
//   MAC_RES_SIZE  - partial-sum width, 2*DATA_SIZE+4
//   FIFO_DEPTH    - default output FIFO depth
//   col_state_e   - collector FSM state
//   entry_t       - FIFO entry {last, data} at the default activation width
package psum_collector_pkg;

    localparam int unsigned DATA_SIZE    = 8;
    localparam int unsigned MAC_RES_SIZE = 2 * DATA_SIZE + 4;
    localparam int unsigned FIFO_DEPTH   = 16;

    typedef enum logic {
        StIdle,
        StCollect
    } col_state_e;

    typedef struct packed {
        logic                        last;
        logic signed [DATA_SIZE-1:0] data;
    } entry_t;

endpackage

// File: rtl/psum_collector_if.sv
// psum_collector_if: result drain bus from the collector FIFO to the output buffer.
//   out_data  - signed FIFO head (0 when empty)
//   out_last  - head entry is the last of its row (0 when empty)
//   out_valid - FIFO not empty
//   out_ready - consumer accepts the head this cycle
// master: collector side, slave: consumer side.
interface psum_collector_if
    import psum_collector_pkg::*;
#(
    parameter int unsigned dataSize = DATA_SIZE
) ();

    logic signed [dataSize-1:0] out_data;
    logic                       out_last;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output out_data,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_last,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/psum_collector_sync_fifo.sv
// psum_collector_sync_fifo: single-clock FIFO, power-of-two depth, fall-through head.
//   clk, nrst - clock, async active-low reset
//   clr_i     - sync clear (empties the FIFO), wins over push/pop
//   push_i    - write wdata_i; accepted when not full or when a pop happens this cycle
//   pop_i     - drop the head; ignored when empty
//   rdata_o   - current head (undefined content when empty)
//   full_o, empty_o, count_o - occupancy status
module psum_collector_sync_fifo #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] DepthC = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthC);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AddrW + 1)'(1);
            2'b01:   count_d = count_q - (AddrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/psum_collector.sv
// psum_collector: downstream stage of a PE column. Counts psums into rows, requantises
// each to activation width with round-half-up, optional ReLU and saturation, and buffers
// the results in a FIFO drained over a valid/ready bus. The PE cannot be stalled, so a
// result arriving at a full FIFO is dropped and flagged.
//   clk, nrst      - clock, async active-low reset
//   clr_i          - sync clear of pipeline, FIFO, row counter and sticky flags
//   psum_i         - signed partial sum, qualified by psum_valid_i
//   pe_done_i      - PE's own end-of-row marker, cross-checked against the row counter
//   cfg_ocount     - outputs per row (0 means 1), latched at the first psum of a row
//   cfg_shift      - requantisation right shift, latched with cfg_ocount
//   cfg_relu       - clamp negatives to 0, latched with cfg_ocount
//   out_if         - result drain bus (master side)
//   flag_row_done  - one-cycle pulse after a last-tagged entry is popped
//   flag_overflow  - sticky, a result was dropped at a full FIFO
//   flag_seq_err   - sticky, pe_done_i disagreed with the internal row count
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int unsigned dataSize   = DATA_SIZE,
    parameter int unsigned macResSize = 2 * dataSize + 4,
    parameter int unsigned fifoDepth  = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         clr_i,
    input  logic signed [macResSize-1:0] psum_i,
    input  logic                         psum_valid_i,
    input  logic                         pe_done_i,
    input  logic [7:0]                   cfg_ocount,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu,
    psum_collector_if.master             out_if,
    output logic                         flag_row_done,
    output logic                         flag_overflow,
    output logic                         flag_seq_err
);

    typedef struct packed {
        logic                       last;
        logic signed [dataSize-1:0] data;
    } col_entry_t;

    localparam int SatMaxI = int'(2 ** (dataSize - 1)) - 1;
    localparam int SatMinI = -int'(2 ** (dataSize - 1));
    localparam logic signed [macResSize:0] SatMax = SatMaxI[macResSize:0];
    localparam logic signed [macResSize:0] SatMin = SatMinI[macResSize:0];

    // Row control
    col_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] ocount_q;
    logic [4:0] shift_q;
    logic       relu_q;

    logic [7:0] ocount_eff, idx_eff;
    logic [4:0] shift_eff;
    logic       relu_eff;
    logic       is_last;
    logic       latch_cfg;

    // Stage 1
    logic                         s1_valid_q;
    logic signed [macResSize-1:0] s1_psum_q;
    logic                         s1_last_q;
    logic [4:0]                   s1_shift_q;
    logic                         s1_relu_q;

    // Stage 2 / FIFO
    logic signed [macResSize:0] ext, rnd, rsum, shifted, relu_r, clamped;
    col_entry_t                 wr_entry, head;
    logic                       fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
    logic [$clog2(fifoDepth):0] fifo_count;
    logic                       unused_fifo_count;

    logic row_done_q, overflow_q, seq_err_q;

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else if (clr_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    // A one-output row ends on its first psum, so the FSM stays in StIdle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (psum_valid_i && !is_last) state_d = StCollect;
            StCollect: if (psum_valid_i && is_last)  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    // In StIdle the incoming psum is index 0 and uses the live cfg; mid-row the latched
    // cfg is used so configuration changes cannot split a row.
    always_comb begin
        latch_cfg  = 1'b0;
        ocount_eff = ocount_q;
        idx_eff    = idx_q;
        shift_eff  = shift_q;
        relu_eff   = relu_q;
        if (state_q == StIdle) begin
            latch_cfg  = psum_valid_i;
            ocount_eff = (cfg_ocount == 8'd0) ? 8'd1 : cfg_ocount;
            idx_eff    = 8'd0;
            shift_eff  = cfg_shift;
            relu_eff   = cfg_relu;
        end
        is_last = (idx_eff == ocount_eff - 8'd1);
        idx_d   = idx_q;
        if (psum_valid_i) begin
            idx_d = is_last ? 8'd0 : idx_eff + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q    <= '0;
            ocount_q <= 8'd1;
            shift_q  <= '0;
            relu_q   <= 1'b0;
        end else if (clr_i) begin
            idx_q    <= '0;
            ocount_q <= 8'd1;
            shift_q  <= '0;
            relu_q   <= 1'b0;
        end else begin
            idx_q <= idx_d;
            if (latch_cfg) begin
                ocount_q <= ocount_eff;
                shift_q  <= cfg_shift;
                relu_q   <= cfg_relu;
            end
        end
    end

    // ---------------------------------------------------------------- stage 1
    // The row's shift/relu travel with the psum so back-to-back rows requantise correctly.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid_q <= 1'b0;
            s1_psum_q  <= '0;
            s1_last_q  <= 1'b0;
            s1_shift_q <= '0;
            s1_relu_q  <= 1'b0;
        end else if (clr_i) begin
            s1_valid_q <= 1'b0;
            s1_psum_q  <= '0;
            s1_last_q  <= 1'b0;
            s1_shift_q <= '0;
            s1_relu_q  <= 1'b0;
        end else begin
            s1_valid_q <= psum_valid_i;
            if (psum_valid_i) begin
                s1_psum_q  <= psum_i;
                s1_last_q  <= is_last;
                s1_shift_q <= shift_eff;
                s1_relu_q  <= relu_eff;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2: requantise
    // One guard bit above the psum width keeps the rounding add from overflowing.
    always_comb begin
        ext = {s1_psum_q[macResSize-1], s1_psum_q};
        rnd = '0;
        if (s1_shift_q != 5'd0) begin
            rnd = {{macResSize{1'b0}}, 1'b1} << (s1_shift_q - 5'd1);
        end
        rsum    = ext + rnd;
        shifted = rsum >>> s1_shift_q;
        relu_r  = (s1_relu_q && shifted[macResSize]) ? '0 : shifted;
        if (relu_r > SatMax) begin
            clamped = SatMax;
        end else if (relu_r < SatMin) begin
            clamped = SatMin;
        end else begin
            clamped = relu_r;
        end
        wr_entry.last = s1_last_q;
        wr_entry.data = clamped[dataSize-1:0];
    end

    // ---------------------------------------------------------------- output FIFO
    assign fifo_pop  = out_if.out_ready && !fifo_empty;
    assign fifo_push = s1_valid_q && (!fifo_full || fifo_pop);
    assign drop      = s1_valid_q && fifo_full && !fifo_pop;

    psum_collector_sync_fifo #(
        .Width (dataSize + 1),
        .Depth (fifoDepth)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .clr_i   (clr_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign unused_fifo_count = ^fifo_count;

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_empty ? '0 : head.data;
    assign out_if.out_last  = fifo_empty ? 1'b0 : head.last;

    // ---------------------------------------------------------------- flags
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_done_q <= 1'b0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else if (clr_i) begin
            row_done_q <= 1'b0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            row_done_q <= fifo_pop && head.last;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (psum_valid_i && (pe_done_i != is_last)) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign flag_row_done = row_done_q;
    assign flag_overflow = overflow_q;
    assign flag_seq_err  = seq_err_q;

endmodule

// File: tb/tb_psum_collector.sv
module tb_psum_collector;
    import psum_collector_pkg::*;

    localparam int Depth = 16;

    logic               clk = 1'b0;
    logic               nrst;
    logic               clr_i;
    logic signed [19:0] psum_i;
    logic               psum_valid_i;
    logic               pe_done_i;
    logic [7:0]         cfg_ocount;
    logic [4:0]         cfg_shift;
    logic               cfg_relu;
    logic               flag_row_done;
    logic               flag_overflow;
    logic               flag_seq_err;

    psum_collector_if out_if ();

    psum_collector dut (
        .clk           (clk),
        .nrst          (nrst),
        .clr_i         (clr_i),
        .psum_i        (psum_i),
        .psum_valid_i  (psum_valid_i),
        .pe_done_i     (pe_done_i),
        .cfg_ocount    (cfg_ocount),
        .cfg_shift     (cfg_shift),
        .cfg_relu      (cfg_relu),
        .out_if        (out_if),
        .flag_row_done (flag_row_done),
        .flag_overflow (flag_overflow),
        .flag_seq_err  (flag_seq_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // sb holds, in order, the results the DUT must present; pend is a result still in the
    // one-cycle pipeline before it reaches the buffer.
    entry_t sb[$];
    entry_t pend;
    bit     pend_v;
    bit     row_open;
    int     row_pos, row_len, row_sh;
    bit     row_relu;
    bit     exp_ovf, exp_seq;

    function automatic int requant(input int p, input int sh, input bit relu);
        longint r;
        r = p;
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic model_clear();
        sb.delete();
        pend_v   = 0;
        row_open = 0;
        row_pos  = 0;
        exp_ovf  = 0;
        exp_seq  = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst || clr_i) begin
                model_clear();
            end else begin
                if (pend_v) begin
                    // sb already reflects this edge's pop, so a slot frees up on a pop.
                    if (sb.size() < Depth) sb.push_back(pend);
                    else exp_ovf = 1;
                end
                pend_v = 0;
                if (psum_valid_i) begin
                    bit last;
                    if (!row_open) begin
                        row_open = 1;
                        row_pos  = 0;
                        row_len  = (cfg_ocount == 0) ? 1 : int'(cfg_ocount);
                        row_sh   = int'(cfg_shift);
                        row_relu = cfg_relu;
                    end
                    last = (row_pos == row_len - 1);
                    if (pe_done_i != last) exp_seq = 1;
                    pend.last = last;
                    pend.data = 8'(requant(int'(psum_i), row_sh, row_relu));
                    pend_v = 1;
                    if (last) row_open = 0;
                    else row_pos++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ------------------------------------------------------------ monitor
    int first_valid_cyc = -1;
    int rd_count = 0;
    int last_seen = 0;
    bit rd_expect = 0;
    int got_data[$];
    bit got_last[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!nrst || clr_i) begin
                rd_expect = 0;
                continue;
            end
            chk("row_done", longint'(flag_row_done), longint'(rd_expect));
            if (flag_row_done) rd_count++;
            chk("overflow", longint'(flag_overflow), longint'(exp_ovf));
            chk("seq_err", longint'(flag_seq_err), longint'(exp_seq));
            chk("out_valid", longint'(out_if.out_valid), longint'(sb.size() > 0));
            rd_expect = 0;
            if (sb.size() > 0) begin
                chk("out_data", longint'(out_if.out_data), longint'(sb[0].data));
                chk("out_last", longint'(out_if.out_last), longint'(sb[0].last));
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_if.out_ready) begin
                    got_data.push_back(int'(out_if.out_data));
                    got_last.push_back(out_if.out_last);
                    if (out_if.out_last) last_seen++;
                    rd_expect = sb[0].last;
                    void'(sb.pop_front());
                end
            end else begin
                chk("empty_data", longint'(out_if.out_data), 0);
                chk("empty_last", longint'(out_if.out_last), 0);
            end
        end
    end

    // ------------------------------------------------------------ stimulus helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int oc, input int sh, input bit rl);
        cfg_ocount = oc[7:0];
        cfg_shift  = sh[4:0];
        cfg_relu   = rl;
    endtask

    task automatic send(input int p, input bit done);
        psum_i       = p[19:0];
        psum_valid_i = 1'b1;
        pe_done_i    = done;
        step();
    endtask

    task automatic quiet(input int n);
        psum_valid_i = 1'b0;
        pe_done_i    = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_obs();
        got_data.delete();
        got_last.delete();
        rd_count        = 0;
        last_seen       = 0;
        first_valid_cyc = -1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_if.out_ready = 1'b1;
        quiet(1);
        while ((sb.size() > 0 || pend_v || out_if.out_valid) && t < 300) begin
            step();
            t++;
        end
        chk("drain_timeout", longint'(t < 300), 1);
        quiet(2);
    endtask

    task automatic pulse_clr();
        psum_valid_i = 1'b0;
        clr_i        = 1'b1;
        step();
        clr_i        = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, longint'(out_if.out_valid), 0);
        chk({tag, "_data"}, longint'(out_if.out_data), 0);
        chk({tag, "_last"}, longint'(out_if.out_last), 0);
        chk({tag, "_rowdone"}, longint'(flag_row_done), 0);
        chk({tag, "_ovf"}, longint'(flag_overflow), 0);
        chk({tag, "_seq"}, longint'(flag_seq_err), 0);
    endtask

    task automatic check_row(input string tag, input int exp_d[], input bit exp_l[]);
        chk({tag, "_count"}, got_data.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), (i < got_data.size()) ? got_data[i] : 9999,
                exp_d[i]);
            chk($sformatf("%s_l%0d", tag, i), (i < got_last.size()) ? got_last[i] : 2,
                exp_l[i]);
        end
    endtask

    // ------------------------------------------------------------ tests
    initial begin
        int issue;
        nrst             = 1'b0;
        clr_i            = 1'b0;
        psum_i           = '0;
        psum_valid_i     = 1'b0;
        pe_done_i        = 1'b0;
        out_if.out_ready = 1'b0;
        set_cfg(4, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        nrst = 1'b1;
        quiet(2);

        // Single row, saturation, latency
        clear_obs();
        set_cfg(4, 0, 0);
        out_if.out_ready = 1'b1;
        issue = cyc;
        send(5, 0);
        send(-3, 0);
        send(100, 0);
        send(-200, 1);
        drain();
        check_row("t1", '{5, -3, 100, -128}, '{0, 0, 0, 1});
        chk("t1_latency", first_valid_cyc - issue, 2);
        chk("t1_rowdone_pulses", rd_count, 1);

        // Rounding and relu
        clear_obs();
        set_cfg(4, 2, 1);
        send(6, 0);
        send(5, 0);
        send(-7, 0);
        send(1000, 1);
        drain();
        check_row("t2", '{2, 1, 0, 127}, '{0, 0, 0, 1});

        // Overflow: 20 psums into a 16-deep FIFO with no consumer
        clear_obs();
        out_if.out_ready = 1'b0;
        set_cfg(20, 0, 0);
        for (int i = 0; i < 20; i++) send(i * 3 - 10, i == 19);
        quiet(3);
        chk("t3_ovf", longint'(flag_overflow), 1);
        chk("t3_seq", longint'(flag_seq_err), 0);
        chk("t3_valid", longint'(out_if.out_valid), 1);
        drain();
        chk("t3_pops", got_data.size(), 16);
        chk("t3_last_seen", last_seen, 0);
        chk("t3_rowdone", rd_count, 0);

        // Full FIFO with simultaneous push and pop
        pulse_clr();
        check_zero("t4_clr");
        clear_obs();
        out_if.out_ready = 1'b0;
        set_cfg(16, 0, 0);
        for (int i = 0; i < 16; i++) send(i + 1, i == 15);
        quiet(3);
        set_cfg(1, 0, 0);
        send(77, 1);
        out_if.out_ready = 1'b1;     // pop coincides with the write of 77
        drain();
        chk("t4_ovf", longint'(flag_overflow), 0);
        chk("t4_pops", got_data.size(), 17);
        chk("t4_tail_data", (got_data.size() == 17) ? got_data[16] : 9999, 77);
        chk("t4_tail_last", (got_last.size() == 17) ? got_last[16] : 2, 1);
        chk("t4_rowdone", rd_count, 2);

        // Sequence error, then clear
        clear_obs();
        set_cfg(3, 0, 0);
        send(1, 0);
        send(2, 1);
        send(3, 0);
        drain();
        chk("t5_seq", longint'(flag_seq_err), 1);
        check_row("t5", '{1, 2, 3}, '{0, 0, 1});
        send(9, 0);                  // open a row, then clear mid-row
        pulse_clr();
        check_zero("t5_clr");
        clear_obs();
        set_cfg(2, 0, 0);
        send(4, 0);
        send(8, 1);
        drain();
        check_row("t5b", '{4, 8}, '{0, 1});
        chk("t5b_seq", longint'(flag_seq_err), 0);

        // Async reset mid-row
        clear_obs();
        set_cfg(4, 0, 0);
        send(10, 0);
        send(20, 0);
        psum_valid_i = 1'b0;
        nrst = 1'b0;
        #2;
        check_zero("t6_rst");
        step();
        nrst = 1'b1;
        quiet(1);
        clear_obs();
        send(-1, 0);
        send(-2, 0);
        send(-3, 0);
        send(-4, 1);
        drain();
        check_row("t6", '{-1, -2, -3, -4}, '{0, 0, 0, 1});
        chk("t6_rowdone", rd_count, 1);

        // Randomised traffic with mid-row cfg changes and back-pressure
        pulse_clr();
        for (int i = 0; i < 600; i++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 19), 1'($urandom_range(0, 1)));
            out_if.out_ready = ($urandom_range(0, 2) != 0);
            clr_i            = ($urandom_range(0, 199) == 0);
            psum_i           = 20'(int'($urandom_range(0, 1048575)) - 524288);
            psum_valid_i     = ($urandom_range(0, 3) != 0);
            pe_done_i        = ($urandom_range(0, 3) == 0);
            step();
        end
        clr_i = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
                 checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Downstream stage of a PE column: consumes the systolic partial-sum stream (psum + valid + done), requantises each sum to activation width, and buffers results in a FIFO.
- Drains results to the output/global buffer over a valid/ready handshake.
- The PE cannot be back-pressured, so the collector absorbs bursts and flags overflow instead of stalling.

Parameters:
- dataSize, 8, activation/output width (signed).
- macResSize, 20, psum width; equals 2*dataSize+4.
- fifoDepth, 16, output FIFO entries; power of two, >=4.

Ports:
- clk  in  1  clock
- nrst  in  1  async active-low reset
- clr_i  in  1  sync clear: empties FIFO and pipeline, zeroes counter and sticky flags
- psum_i  in  macResSize  signed partial sum from last PE of column
- psum_valid_i  in  1  psum_i valid this cycle
- pe_done_i  in  1  PE flag: asserted with the final psum of a row
- cfg_ocount  in  8  outputs per row; 0 treated as 1
- cfg_shift  in  5  right-shift for requantisation, 0..macResSize-1
- cfg_relu  in  1  clamp negatives to 0
- out_data  out  dataSize  signed FIFO head; 0 when empty
- out_last  out  1  head entry is last of row; 0 when empty
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head
- flag_row_done  out  1  1-cycle pulse when a last-tagged entry is popped
- flag_overflow  out  1  sticky: a result was dropped because the FIFO was full
- flag_seq_err  out  1  sticky: pe_done_i disagreed with internal count

Behaviour:
- Reset/clr: all outputs 0; FIFO empty; state IDLE; counter 0; stage-1 valid 0. clr_i takes priority over every other event in that cycle.
- FSM states:
  - IDLE: on psum_valid_i, latch cfg_ocount/cfg_shift/cfg_relu, go to COLLECT, and accept that psum as index 0.
  - COLLECT: each psum_valid_i increments idx. When a psum with idx==ocount_lat-1 is accepted, tag it last, reset idx to 0, and return to IDLE.
  - cfg changes mid-row are ignored.
- Sequence check: on an accepted psum, set flag_seq_err if pe_done_i != (idx==ocount_lat-1). The internal count always decides the last tag.
- Pipeline:
  - Stage 1 registers psum, last tag and valid at the edge ending cycle N.
  - Stage 2 requantises combinationally from stage 1 and writes the FIFO at the edge ending N+1.
  - out_valid is high in N+2 at the earliest. Latency is 2 cycles with the FIFO empty.
- Requantisation, computed at macResSize+1 bits:
  - r = psum + (cfg_shift>0 ? 1<<(cfg_shift-1) : 0), then arithmetic shift right by cfg_shift (round half up).
  - If relu and r<0, r=0.
  - Saturate to [-2^(dataSize-1), 2^(dataSize-1)-1]; e.g. 127/-128 for dataSize 8.
- FIFO:
  - Pop when out_valid && out_ready.
  - Write when stage-1 valid and (not full, or a pop occurs the same cycle). Simultaneous push+pop when full is legal and the count is unchanged.
  - Write when full without a pop drops the entry and sets flag_overflow. The row counter still advances.
  - Pop when empty is a no-op; out_ready is ignored.
  - Pointers wrap at fifoDepth; the count field is log2(fifoDepth)+1 bits.
- flag_row_done: registered, high for the cycle after a pop of an entry with last=1.
- Back-to-back rows with no gap are legal. A psum arriving the cycle after the last one starts a new row with freshly latched cfg.
- Async reset mid-row discards everything; no partial row survives.

Decomposition:
- Shared package (pe_pkg): MAC_RES_SIZE = 2*DATA_SIZE+4, collector state enum {IDLE, COLLECT}, and a packed struct for an entry {logic last; logic signed [dataSize-1:0] data}.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count), reusable by the global-buffer path.

Test Plan:
- Single row: ocount=4, shift=0, relu=0, psums 5,-3,100,-200 with done on the 4th; out_ready=1 → out 5,-3,100,-128; out_last on the 4th only; flag_row_done one pulse; latency 2 cycles.
- Rounding/relu: shift=2, relu=1, psums 6,5,-7,1000 → 2,1,0,127.
- Overflow: fifoDepth=16, out_ready=0, 20 consecutive psums with ocount=20 → 16 entries held, flag_overflow=1, no seq_err. Then out_ready=1 → 16 pops; out_last never seen; no row_done.
- Full with push+pop: FIFO full, out_ready=1 while one psum arrives → count stays 16, no overflow, new entry is last in order.
- Sequence error: ocount=3, pe_done_i asserted on the 2nd psum → flag_seq_err=1; last tag still on the 3rd. clr_i then clears flags, FIFO and counter.
- Reset mid-row: nrst pulsed after 2 of 4 psums → all outputs 0. A new 4-psum row then completes normally with row_done.
